stage4_normalize: RTL and testbench

STAGE4_NORMALIZE -- requirements
Module: stage4_normalize

---
 rtl/stage4_normalize_pkg.sv | 25 ++
 rtl/stage4_normalize_lzc.sv | 21 ++
 rtl/stage4_normalize.sv | 112 +++++++++++
 tb/tb_stage4_normalize.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stage4_normalize_pkg.sv
// Shared MAC field layout, exponent bias and saturation limits for the Stage4 normalizer.
// Also holds the registered record passed from sub-stage A to sub-stage B.
package stage4_normalize_pkg;

   localparam int CARRY_BIT   = 13;
   localparam int HIDDEN_BIT  = 12;
   localparam int FRAC_LSB    = 2;
   localparam int GUARD_BIT   = 1;
   localparam int STICKY_BIT  = 0;
   localparam int LZC_IN_W    = 14;
   localparam int LZC_CNT_W   = 4;
   localparam int NORM_W      = 11;
   localparam int EXP_BIAS    = 15;
   localparam int EXP_SAT_MAX = 63;
   localparam int EXP_SAT_MIN = -64;

   // lead is the leading-one position: 13 for the carry case, 0..12 otherwise
   typedef struct packed {
      logic                 sign;
      logic                 zero;
      logic [LZC_CNT_W-1:0] lead;
      logic [LZC_IN_W-1:0]  aligned;
   } stage_a_t;

endpackage

// File: rtl/stage4_normalize_lzc.sv
// Combinational leading-zero counter over the 14-bit magnitude.
// count is zeros above the leading one; zero flags an all-zero input (count reads 14).
module leading_zero_count
   import stage4_normalize_pkg::*;
(
   input  logic [LZC_IN_W-1:0]  din,
   output logic [LZC_CNT_W-1:0] count,
   output logic                 zero
);

   // Ascending scan, so the highest set bit is the last to write count
   always_comb begin
      count = LZC_CNT_W'(LZC_IN_W);
      for (int i = 0; i < LZC_IN_W; i++) begin
         if (din[i]) count = LZC_CNT_W'(LZC_IN_W - 1 - i);
      end
   end

   assign zero = ~|din;

endmodule

// File: rtl/stage4_normalize.sv
// Stage4 normalize: A aligns the magnitude so hidden sits at bit 12 and records the leading-one position;
// B rounds to nearest even, applies the exponent adjustment and saturates.
module stage4_normalize
   import stage4_normalize_pkg::*;
#(
   parameter int SUM_W = 14,
   parameter int EXP_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              hold,
   input  logic              sign_in,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic [SUM_W-1:0]  sum_in,
   output logic              valid_out,
   output logic              sign,
   output logic [EXP_W-1:0]  exp_final,
   output logic [NORM_W-1:0] norm_sum
);

   localparam int STAGES = 2;
   localparam int XW     = EXP_W + 2;

   localparam logic signed [XW-1:0]  HID_X    = XW'(HIDDEN_BIT);
   localparam logic signed [XW-1:0]  ONE_X    = XW'(1);
   localparam logic signed [XW-1:0]  SAT_HI   = XW'(EXP_SAT_MAX);
   localparam logic signed [XW-1:0]  SAT_LO   = XW'(EXP_SAT_MIN);
   localparam logic [NORM_W-1:0]     NORM_ONE = {1'b1, {(NORM_W-1){1'b0}}};

   logic [LZC_CNT_W-1:0] lz_cnt;
   logic                 lz_zero;

   leading_zero_count u_lzc (
      .din   (sum_in),
      .count (lz_cnt),
      .zero  (lz_zero)
   );

   // ---------------- sub-stage A: alignment ----------------
   stage_a_t a_d, a_q;
   logic [EXP_W-1:0] a_exp_q;

   always_comb begin
      a_d      = '0;
      a_d.sign = sign_in;
      a_d.zero = lz_zero;
      if (sum_in[CARRY_BIT]) begin
         // shift right one; the dropped bit folds into sticky
         a_d.lead    = LZC_CNT_W'(CARRY_BIT);
         a_d.aligned = {1'b0, sum_in[CARRY_BIT:FRAC_LSB], sum_in[GUARD_BIT] | sum_in[STICKY_BIT]};
      end else if (!lz_zero) begin
         a_d.lead    = LZC_CNT_W'(CARRY_BIT) - lz_cnt;
         a_d.aligned = sum_in << (lz_cnt - LZC_CNT_W'(1));
      end
   end

   // ---------------- sub-stage B: round, exponent, saturate ----------------
   logic                    rnd_up;
   logic [NORM_W:0]         mant_r;
   logic signed [XW-1:0]    exp_x, lead_x, exp_r;
   logic                    b_sign;
   logic [EXP_W-1:0]        b_exp;
   logic [NORM_W-1:0]       b_norm;

   always_comb begin
      rnd_up = a_q.aligned[GUARD_BIT] & (a_q.aligned[STICKY_BIT] | a_q.aligned[FRAC_LSB]);
      mant_r = {a_q.aligned[CARRY_BIT], a_q.aligned[HIDDEN_BIT:FRAC_LSB]} + {{NORM_W{1'b0}}, rnd_up};
      exp_x  = {{2{a_exp_q[EXP_W-1]}}, a_exp_q};
      lead_x = {{(XW-LZC_CNT_W){1'b0}}, a_q.lead};
      // lead - 12 is +1 for carry and -(12-p) for a left shift
      exp_r  = exp_x + lead_x - HID_X;
      b_norm = mant_r[NORM_W-1:0];
      if (mant_r[NORM_W]) begin
         b_norm = NORM_ONE;
         exp_r  = exp_r + ONE_X;
      end
      if (exp_r > SAT_HI)      b_exp = SAT_HI[EXP_W-1:0];
      else if (exp_r < SAT_LO) b_exp = SAT_LO[EXP_W-1:0];
      else                     b_exp = exp_r[EXP_W-1:0];
      b_sign = a_q.sign;
      if (a_q.zero) begin
         b_sign = 1'b0;
         b_exp  = '0;
         b_norm = '0;
      end
   end

   // ---------------- registers ----------------
   logic [STAGES:1] vld_pipe;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_pipe  <= '0;
         a_q       <= '0;
         a_exp_q   <= '0;
         sign      <= 1'b0;
         exp_final <= '0;
         norm_sum  <= '0;
      end else if (!hold) begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], valid_in};
         a_q       <= a_d;
         a_exp_q   <= exp_in;
         sign      <= b_sign;
         exp_final <= b_exp;
         norm_sum  <= b_norm;
      end
   end

   assign valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_stage4_normalize.sv
// Scoreboard bench for stage4_normalize: expected beats are queued at capture and matched at output.
module tb_stage4_normalize;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic        hold = 1'b0;
   logic        sign_in = 1'b0;
   logic [6:0]  exp_in = '0;
   logic [13:0] sum_in = '0;
   logic        valid_out;
   logic        sign;
   logic [6:0]  exp_final;
   logic [10:0] norm_sum;

   stage4_normalize #(.SUM_W(14), .EXP_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .hold      (hold),
      .sign_in   (sign_in),
      .exp_in    (exp_in),
      .sum_in    (sum_in),
      .valid_out (valid_out),
      .sign      (sign),
      .exp_final (exp_final),
      .norm_sum  (norm_sum)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int e;
      int n;
      int due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   adv = 0;
   bit   dir_en = 1'b0;
   int   dir_s = 0, dir_e = 0, dir_n = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: normalize by repeated doubling, then round-half-even on guard/sticky
   function automatic void model(input bit s, input int e_in, input int x,
                                 output int os, output int oe, output int on);
      int m, k, e, g, st;
      os = 0; oe = 0; on = 0;
      if (x == 0) return;
      m = x;
      e = e_in;
      while (m < 'h1000) begin
         m = m << 1;
         e = e - 1;
      end
      if (m >= 'h2000) begin
         m = (m >> 1) | (m & 1);
         e = e + 1;
      end
      k  = m >> 2;
      g  = (m >> 1) & 1;
      st = m & 1;
      if (g != 0 && (st != 0 || (k & 1) != 0)) k = k + 1;
      if (k == 'h800) begin
         k = 'h400;
         e = e + 1;
      end
      if (e > 63)  e = 63;
      if (e < -64) e = -64;
      os = s; oe = e; on = k;
   endfunction

   // Monitor: sample controls at the edge, judge outputs 1 time unit later
   logic p_v, p_s;
   logic [6:0]  p_e;
   logic [10:0] p_n;

   always @(posedge clk) begin
      logic r_s, h_s, v_s, s_s, d_s;
      logic [6:0]  e_s;
      logic [13:0] x_s;
      int ds, de, dn, ms, me, mn;
      exp_t it;
      r_s = rst; h_s = hold; v_s = valid_in; s_s = sign_in; e_s = exp_in; x_s = sum_in;
      d_s = dir_en; ds = dir_s; de = dir_e; dn = dir_n;
      #1;
      if (!r_s) begin
         sb.delete();
         chk("rst_valid", valid_out, 0);
         chk("rst_sign", sign, 0);
         chk("rst_exp", $signed(exp_final), 0);
         chk("rst_norm", norm_sum, 0);
      end else if (h_s) begin
         chk("hold_valid", valid_out, p_v);
         chk("hold_sign", sign, p_s);
         chk("hold_exp", exp_final, p_e);
         chk("hold_norm", norm_sum, p_n);
      end else begin
         adv++;
         if (valid_out === 1'b1) begin
            if (sb.size() == 0) chk("unexpected", valid_out, 0);
            else begin
               it = sb.pop_front();
               chk("latency", adv, it.due);
               chk("sign", sign, it.s);
               chk("exp", $signed(exp_final), it.e);
               chk("norm", norm_sum, it.n);
            end
         end else if (sb.size() > 0 && sb[0].due == adv) begin
            chk("missing", valid_out, 1);
            void'(sb.pop_front());
         end
         if (v_s) begin
            if (d_s) begin
               it.s = ds; it.e = de; it.n = dn;
            end else begin
               model(s_s, int'($signed(e_s)), int'(x_s), ms, me, mn);
               it.s = ms; it.e = me; it.n = mn;
            end
            it.due = adv + 1;
            sb.push_back(it);
         end
      end
      p_v = valid_out; p_s = sign; p_e = exp_final; p_n = norm_sum;
   end

   task automatic beat(input bit v, input bit h, input bit s, input int e, input int x);
      @(negedge clk);
      valid_in = v; hold = h; sign_in = s; exp_in = 7'(e); sum_in = 14'(x); dir_en = 1'b0;
   endtask

   task automatic dbeat(input bit s, input int e, input int x, input int es, input int ee, input int en);
      @(negedge clk);
      valid_in = 1'b1; hold = 1'b0; sign_in = s; exp_in = 7'(e); sum_in = 14'(x);
      dir_en = 1'b1; dir_s = es; dir_e = ee; dir_n = en;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      idle(2);
      @(negedge clk) rst = 1'b1;
      // directed vectors
      dbeat(1'b1,  15, 'h1000, 1,  15, 'h400);
      dbeat(1'b0,  15, 'h2000, 0,  16, 'h400);
      dbeat(1'b0,  20, 'h0010, 0,  12, 'h400);
      dbeat(1'b0,  15, 'h1FFE, 0,  16, 'h400);
      dbeat(1'b0,  15, 'h1002, 0,  15, 'h400);
      dbeat(1'b1, -60, 'h0001, 1, -64, 'h400);
      dbeat(1'b1,  33, 'h0000, 0,   0, 'h000);
      dbeat(1'b0,  63, 'h3FFF, 0,  63, 'h400);
      dbeat(1'b1,   0, 'h1006, 1,   0, 'h402);
      idle(3);
      // random traffic with bubbles and occasional stalls
      for (int i = 0; i < 80; i++) begin
         int w;
         w = $urandom_range(1, 14);
         beat($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
              int'($urandom_range(0, 127)) - 64, int'($urandom & ((32'd1 << w) - 1)));
      end
      idle(3);
      // four-beat stream with a 3-cycle hold after the second beat
      beat(1'b1, 1'b0, 1'b0,  5, 'h0ABC);
      beat(1'b1, 1'b0, 1'b1, -3, 'h2A55);
      beat(1'b1, 1'b1, 1'b0,  9, 'h0003);
      beat(1'b1, 1'b1, 1'b0,  9, 'h0003);
      beat(1'b1, 1'b1, 1'b0,  9, 'h0003);
      beat(1'b1, 1'b0, 1'b1, 40, 'h17FF);
      beat(1'b1, 1'b0, 1'b0, -7, 'h0555);
      idle(4);
      // reset with two beats in flight
      beat(1'b1, 1'b0, 1'b0, 10, 'h0800);
      @(negedge clk);
      valid_in = 1'b1; sum_in = 14'h0321; rst = 1'b0; dir_en = 1'b0;
      @(negedge clk);
      rst = 1'b1; valid_in = 1'b0;
      idle(3);
      dbeat(1'b0, 2, 'h0400, 0, 0, 'h400);
      idle(2);
      for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
      chk("drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
